my_keypad_4x4: RTL and testbench

MY_KEYPAD_4X4 -- requirements
Module: my_keypad_4x4

---
 rtl/my_keypad_4x4.sv | 171 +++++++++++++++++
 tb/tb_my_keypad_4x4.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_keypad_4x4.sv
// 4x4 matrix keypad scanner with frame-based debounce and a valid/ready key-event output.
// Optional auto-repeat is compiled in when MY_KEYPAD_AUTOREPEAT_EN is defined.
module my_keypad_4x4 #(
  parameter int unsigned SCAN_DIV      = 1024,
  parameter int unsigned DEB_CNT       = 4,
  parameter int unsigned REPEAT_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_rdy,
  output logic       key_down,
  output logic       key_ovf
);

  localparam int unsigned   DwW    = $clog2(SCAN_DIV);
  localparam logic [DwW-1:0] DwMax = DwW'(SCAN_DIV - 1);
  localparam logic [3:0]    DebMax = 4'(DEB_CNT);

  if (SCAN_DIV < 4 || DEB_CNT < 1 || DEB_CNT > 15 || REPEAT_FRAMES < 1) begin : g_bad_param
    $error("my_keypad_4x4: illegal parameter value");
  end

  logic [3:0]     r_col_s1, r_col_s2;
  logic           r_active;
  logic [DwW-1:0] r_dwell;
  logic [1:0]     r_row_idx;
  logic [1:0]     r_acc_cnt;   // keys seen so far in this frame, saturates at 2
  logic [3:0]     r_acc_code;
  logic [4:0]     r_prev;      // {valid, code}; 5'd0 means no key
  logic [4:0]     r_stable;
  logic [3:0]     r_match;
  logic [3:0]     r_key;
  logic           r_key_valid;
  logic           r_key_ovf;

  logic       w_sample, w_frame_end;
  logic [3:0] w_pressed;
  logic [2:0] w_ncols, w_sum;
  logic [1:0] w_col_idx, w_tot;
  logic [3:0] w_code, w_match_nxt, w_event_code;
  logic [4:0] w_res;
  logic       w_accept, w_change, w_new_key, w_repeat, w_event;

  assign w_sample    = r_active && en && (r_dwell == DwMax);
  assign w_frame_end = w_sample && (r_row_idx == 2'd3);
  assign w_pressed   = ~r_col_s2;

  always_comb begin
    w_ncols   = '0;
    w_col_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_pressed[i]) begin
        w_ncols   = w_ncols + 3'd1;
        w_col_idx = 2'(i);
      end
    end
    w_sum = {1'b0, r_acc_cnt} + w_ncols;
    w_tot = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  end

  assign w_code      = (r_acc_cnt == 2'd0) ? {r_row_idx, w_col_idx} : r_acc_code;
  assign w_res       = (w_tot == 2'd1) ? {1'b1, w_code} : 5'd0;
  assign w_match_nxt = (w_res != r_prev) ? 4'd1 :
                       (r_match >= DebMax) ? r_match : r_match + 4'd1;
  assign w_accept    = w_frame_end && (w_match_nxt == DebMax);
  assign w_change    = w_accept && (w_res != r_stable);
  assign w_new_key   = w_change && w_res[4];

`ifdef MY_KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_FRAMES) + 1;
  logic [RepW-1:0] r_rep_cnt;
  logic            w_rep_hit;

  assign w_rep_hit = (r_rep_cnt == RepW'(REPEAT_FRAMES - 1));
  assign w_repeat  = w_frame_end && r_stable[4] && !w_change && w_rep_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else if (!en || w_change) begin
      r_rep_cnt <= '0;
    end else if (w_frame_end && r_stable[4]) begin
      r_rep_cnt <= w_rep_hit ? '0 : r_rep_cnt + RepW'(1);
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  assign w_event      = w_new_key || w_repeat;
  assign w_event_code = w_new_key ? w_res[3:0] : r_stable[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_s1   <= 4'hF;
      r_col_s2   <= 4'hF;
      r_active   <= 1'b0;
      r_dwell    <= '0;
      r_row_idx  <= '0;
      r_acc_cnt  <= '0;
      r_acc_code <= '0;
      r_prev     <= '0;
      r_match    <= '0;
      r_stable   <= '0;
    end else begin
      r_col_s1 <= col;
      r_col_s2 <= r_col_s1;
      if (!en) begin
        r_active   <= 1'b0;
        r_dwell    <= '0;
        r_row_idx  <= '0;
        r_acc_cnt  <= '0;
        r_acc_code <= '0;
        r_prev     <= '0;
        r_match    <= '0;
        r_stable   <= '0;
      end else begin
        // First enabled cycle only arms the scan so row 0 gets a full dwell.
        r_active <= 1'b1;
        if (r_active) begin
          if (w_sample) begin
            r_dwell   <= '0;
            r_row_idx <= r_row_idx + 2'd1;
            if (w_frame_end) begin
              r_acc_cnt  <= '0;
              r_acc_code <= '0;
              r_prev     <= w_res;
              r_match    <= w_match_nxt;
              if (w_accept) r_stable <= w_res;
            end else begin
              r_acc_cnt  <= w_tot;
              r_acc_code <= w_code;
            end
          end else begin
            r_dwell <= r_dwell + DwW'(1);
          end
        end
      end
    end
  end

  // Pending events survive en going low; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_ovf   <= 1'b0;
    end else if (w_event) begin
      if (!r_key_valid || key_rdy) begin
        r_key       <= w_event_code;
        r_key_valid <= 1'b1;
      end else begin
        r_key_ovf <= 1'b1;
      end
    end else if (r_key_valid && key_rdy) begin
      r_key_valid <= 1'b0;
    end
  end

  assign row       = (r_active && en) ? ~(4'b0001 << r_row_idx) : 4'hF;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_ovf   = r_key_ovf;
  assign key_down  = r_stable[4] && en;

endmodule

// File: tb/tb_my_keypad_4x4.sv
// Randomized and directed bench for my_keypad_4x4 against a frame-level behavioural model.
module tb_my_keypad_4x4;
  localparam int unsigned SCAN_DIV      = 8;
  localparam int unsigned DEB_CNT       = 3;
  localparam int unsigned REPEAT_FRAMES = 4;
  localparam int          FRAME         = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       key_rdy = 1'b0;
  logic [3:0] row, col, key;
  logic       key_valid, key_down, key_ovf;
  logic [15:0] g_mask = '0;  // bit r*4+c = key at (row r, col c) pressed

  int checks = 0;
  int failures = 0;

  // Behavioural model state: results are -1 (no key) or a key code 0..15.
  bit  m_active;
  int  m_pos;
  int  m_hist[$];
  int  m_stable;
  int  m_rep;
  bit  m_valid;
  int  m_key;
  bit  m_ovf;
  int  m_ev_cnt;

  int         n_vld, first_fe, fe_cnt;
  bit         first_after_fe;
  logic [3:0] first_key;

  my_keypad_4x4 #(
    .SCAN_DIV     (SCAN_DIV),
    .DEB_CNT      (DEB_CNT),
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_rdy  (key_rdy),
    .key_down (key_down),
    .key_ovf  (key_ovf)
  );

  always #5 clk = ~clk;

  // Passive keypad matrix: a pressed key shorts its column to its driven-low row.
  always_comb begin
    col = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!row[r] && g_mask[r*4+c]) col[c] = 1'b0;
  end

  function automatic int frame_result(logic [15:0] m);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < 16; i++) if (m[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_hist.delete(); m_stable = -1; m_rep = 0;
    m_valid = 0; m_key = 0; m_ovf = 0; m_ev_cnt = 0;
  endtask

  task automatic step();
    bit fe, ev, same;
    int res, evkey;
    @(posedge clk);
    fe = 0; ev = 0; evkey = 0;
    if (!en) begin
      m_active = 0; m_pos = 0; m_hist.delete(); m_stable = -1; m_rep = 0;
    end else if (!m_active) begin
      m_active = 1; m_pos = 0;
    end else begin
      fe = (m_pos == FRAME - 1);
      m_pos = (m_pos + 1) % FRAME;
    end
    if (fe) begin
      fe_cnt++;
      res = frame_result(g_mask);
      m_hist.push_back(res);
      if (m_hist.size() > 16) void'(m_hist.pop_front());
      same = (m_hist.size() >= int'(DEB_CNT));
      for (int i = 0; i < int'(DEB_CNT) && same; i++)
        if (m_hist[m_hist.size()-1-i] != res) same = 0;
      if (same && res != m_stable) begin
        m_stable = res; m_rep = 0;
        if (res >= 0) begin ev = 1; evkey = res; end
      end else if (m_stable >= 0) begin
`ifdef MY_KEYPAD_AUTOREPEAT_EN
        m_rep++;
        if (m_rep == int'(REPEAT_FRAMES)) begin m_rep = 0; ev = 1; evkey = m_stable; end
`endif
      end
    end
    if (ev) begin
      m_ev_cnt++;
      if (!m_valid || key_rdy) begin m_valid = 1; m_key = evkey; end
      else m_ovf = 1;
    end else if (m_valid && key_rdy) begin
      m_valid = 0;
    end
    #1;
    if (key_valid === 1'b1) begin
      n_vld++;
      if (n_vld == 1) begin first_fe = fe_cnt; first_after_fe = fe; first_key = key; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; key_rdy = 1'b0; g_mask = '0;
    model_reset();
    #12;
    rst_n = 1'b1;
    step();
    n_vld = 0; fe_cnt = 0; m_ev_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (row !== 4'hF) begin failures++; $display("FAIL reset_row got=%h exp=F", row); end
    checks++; if (key !== 4'h0) begin failures++; $display("FAIL reset_key got=%h exp=0", key); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL reset_down got=%b exp=0", key_down); end
    checks++; if (key_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", key_ovf); end
  endtask

  task automatic test_single_press();
    int exp_n;
`ifdef MY_KEYPAD_AUTOREPEAT_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    do_reset();
    key_rdy = 1'b1; g_mask = 16'h0200;
    repeat (10 * FRAME) step();
    checks++; if (n_vld !== exp_n) begin failures++; $display("FAIL press_count got=%0d exp=%0d", n_vld, exp_n); end
    checks++; if (first_fe !== 3 || first_after_fe !== 1'b1) begin
      failures++; $display("FAIL press_latency got_fe=%0d after_fe=%0b exp_fe=3 after_fe=1", first_fe, first_after_fe);
    end
    checks++; if (first_key !== 4'h9) begin failures++; $display("FAIL press_key got=%h exp=9", first_key); end
    checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL press_down got=%b exp=1", key_down); end
    g_mask = '0;
    repeat (3 * FRAME - 1) step();
    checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL release_down_hold got=%b exp=1", key_down); end
    step();
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL release_down_drop got=%b exp=0", key_down); end
    checks++; if (n_vld !== m_ev_cnt) begin failures++; $display("FAIL release_events got=%0d exp=%0d", n_vld, m_ev_cnt); end
  endtask

  task automatic test_bounce();
    do_reset();
    key_rdy = 1'b1;
    for (int f = 0; f < 4; f++) begin
      g_mask = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (FRAME) step();
    end
    g_mask = 16'h0200;
    repeat (5 * FRAME) step();
    checks++; if (n_vld !== 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", n_vld); end
    checks++; if (first_fe !== 7) begin failures++; $display("FAIL bounce_latency got=%0d exp=7", first_fe); end
    checks++; if (first_key !== 4'h9) begin failures++; $display("FAIL bounce_key got=%h exp=9", first_key); end
  endtask

  task automatic test_ghost();
    do_reset();
    key_rdy = 1'b1; g_mask = 16'h0081;
    repeat (10 * FRAME) step();
    checks++; if (n_vld !== 0) begin failures++; $display("FAIL ghost_count got=%0d exp=0", n_vld); end
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL ghost_down got=%b exp=0", key_down); end
  endtask

  task automatic test_overflow();
    do_reset();
    key_rdy = 1'b0;
    g_mask = 16'h0020; repeat (5 * FRAME) step();
    g_mask = 16'h0000; repeat (5 * FRAME) step();
    g_mask = 16'h0080; repeat (5 * FRAME) step();
    checks++; if (key !== 4'h5) begin failures++; $display("FAIL ovf_key got=%h exp=5", key); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", key_valid); end
    checks++; if (key_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", key_ovf); end
    key_rdy = 1'b1; step(); key_rdy = 1'b0;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL ovf_accept_valid got=%b exp=0", key_valid); end
    checks++; if (key_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", key_ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    key_rdy = 1'b0; g_mask = 16'h0200;
    repeat (3 * FRAME) step();
    checks++; if (key_valid !== 1'b1 || key !== 4'h9) begin
      failures++; $display("FAIL mid_pending got=%b/%h exp=1/9", key_valid, key);
    end
    repeat (2 * SCAN_DIV + 5) step();
    checks++; if (row !== 4'b1011) begin failures++; $display("FAIL mid_row2 got=%b exp=1011", row); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (row !== 4'hF || key !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0 || key_ovf !== 1'b0) begin
      failures++;
      $display("FAIL mid_async got row=%b key=%h v=%b d=%b o=%b exp row=1111 key=0 v=0 d=0 o=0",
               row, key, key_valid, key_down, key_ovf);
    end
    g_mask = '0;
    #3;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < int'(SCAN_DIV); i++) begin
      checks++; if (row !== 4'b1110) begin failures++; $display("FAIL mid_restart_row cyc=%0d got=%b exp=1110", i, row); end
      step();
    end
    checks++; if (row !== 4'b1101) begin failures++; $display("FAIL mid_next_row got=%b exp=1101", row); end
  endtask

  task automatic test_enable();
    do_reset();
    key_rdy = 1'b0; g_mask = 16'h0200;
    repeat (3 * FRAME + 4) step();
    en = 1'b0;
    #1;
    checks++; if (row !== 4'hF) begin failures++; $display("FAIL en_row_comb got=%b exp=1111", row); end
    step();
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL en_down got=%b exp=0", key_down); end
    checks++; if (key_valid !== 1'b1 || key !== 4'h9) begin
      failures++; $display("FAIL en_retain got=%b/%h exp=1/9", key_valid, key);
    end
    repeat (5) step();
    en = 1'b1;
    step();
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL en_restart_row got=%b exp=1110", row); end
    repeat (3 * FRAME) step();
    checks++; if (key_ovf !== 1'b1 || key !== 4'h9) begin
      failures++; $display("FAIL en_reovf got=%b/%h exp=1/9", key_ovf, key);
    end
  endtask

  task automatic test_hold();
    int exp_n;
`ifdef MY_KEYPAD_AUTOREPEAT_EN
    exp_n = 5;
`else
    exp_n = 1;
`endif
    do_reset();
    key_rdy = 1'b1; g_mask = 16'h0008;
    repeat (20 * FRAME) step();
    checks++; if (n_vld !== exp_n) begin failures++; $display("FAIL hold_count got=%0d exp=%0d", n_vld, exp_n); end
    checks++; if (key !== 4'h3) begin failures++; $display("FAIL hold_key got=%h exp=3", key); end
  endtask

  task automatic test_random();
    logic [3:0] exp_row;
    int r;
    do_reset();
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(0, 9);
      if (r >= 5 && r < 7) g_mask = 16'h1 << $urandom_range(0, 15);
      else if (r == 7) g_mask = '0;
      else if (r >= 8) g_mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      for (int c = 0; c < FRAME; c++) begin
        key_rdy = ($urandom_range(0, 3) == 0);
        step();
        exp_row = m_active ? ~(4'b0001 << (m_pos / int'(SCAN_DIV))) : 4'hF;
        checks++; if (key_valid !== m_valid) begin
          failures++; if (failures < 40) $display("FAIL rnd_valid f=%0d c=%0d got=%b exp=%b", f, c, key_valid, m_valid);
        end
        if (m_valid) begin
          checks++; if (key !== 4'(m_key)) begin
            failures++; if (failures < 40) $display("FAIL rnd_key f=%0d c=%0d got=%h exp=%h", f, c, key, m_key);
          end
        end
        checks++; if (key_down !== (m_stable >= 0)) begin
          failures++; if (failures < 40) $display("FAIL rnd_down f=%0d c=%0d got=%b exp=%b", f, c, key_down, m_stable >= 0);
        end
        checks++; if (key_ovf !== m_ovf) begin
          failures++; if (failures < 40) $display("FAIL rnd_ovf f=%0d c=%0d got=%b exp=%b", f, c, key_ovf, m_ovf);
        end
        checks++; if (row !== exp_row) begin
          failures++; if (failures < 40) $display("FAIL rnd_row f=%0d c=%0d got=%b exp=%b", f, c, row, exp_row);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_overflow();
    test_reset_mid();
    test_enable();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
